sram_bank_arbiter: RTL and testbench

SRAM_BANK_ARBITER -- requirements
Module: sram_bank_arbiter

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_bank_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/sram_bank_arbiter.sv | 119 +++++++++++
 tb/tb_sram_bank_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the SRAM bank arbiter.
package sram_arb_pkg;

   localparam int unsigned DefaultNumWords = 8192;
   localparam int unsigned DataWidth       = 32;
   localparam int unsigned StrbWidth       = DataWidth / 8;

   typedef enum logic [2:0] {
      ST_ACTIVE = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_GATE   = 3'd2,
      ST_SLEEP  = 3'd3,
      ST_WAKE   = 3'd4
   } state_e;

endpackage

// File: rtl/sram_bank_arbiter_if.sv
// Requester-side bus of the SRAM bank arbiter: per-port request, grant and response.
interface sram_bank_arbiter_if #(
   parameter int unsigned NumPorts  = 2,
   parameter int unsigned AddrWidth = $clog2(sram_arb_pkg::DefaultNumWords)
);
   import sram_arb_pkg::*;

   logic [NumPorts-1:0]                 req_i;
   logic [NumPorts-1:0]                 we_i;
   logic [NumPorts-1:0][AddrWidth-1:0]  addr_i;
   logic [NumPorts-1:0][DataWidth-1:0]  wdata_i;
   logic [NumPorts-1:0][StrbWidth-1:0]  be_i;
   logic [NumPorts-1:0]                 gnt_o;
   logic [NumPorts-1:0]                 rvalid_o;
   logic [NumPorts-1:0][DataWidth-1:0]  rdata_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i,
      output gnt_o, rvalid_o, rdata_o
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first requesting port at or after ptr, wrapping modulo NumPorts.
module rr_arbiter #(
   parameter int unsigned NumPorts = 2,
   parameter int unsigned IdxWidth = $clog2(NumPorts)
) (
   input  logic [NumPorts-1:0] req,
   input  logic [IdxWidth-1:0] ptr,
   output logic [NumPorts-1:0] gnt,
   output logic [IdxWidth-1:0] idx
);

   logic        found;
   int unsigned cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int unsigned off = 0; off < NumPorts; off++) begin
         cand = (32'(ptr) + off) % NumPorts;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IdxWidth'(cand);
         end
      end
   end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Shares one SRAM bank between NumPorts requesters with round-robin grants, and
// sequences the bank through drain, power-gate, sleep and wake on system request.
module sram_bank_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NumPorts       = 2,
   parameter int unsigned NumWords       = DefaultNumWords,
   parameter int unsigned AddrWidth      = $clog2(NumWords),
   parameter bit          RetentiveSleep = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   sram_bank_arbiter_if.slave    bus,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [AddrWidth-1:0]  mem_addr_o,
   output logic [DataWidth-1:0]  mem_wdata_o,
   output logic [StrbWidth-1:0]  mem_be_o,
   input  logic [DataWidth-1:0]  mem_rdata_i,
   output logic                  mem_pwrgate_no,
   output logic                  mem_set_retentive_no,
   input  logic                  mem_pwrgate_ack_ni,
   input  logic                  sleep_req_i,
   output logic                  sleep_ack_o
);

   localparam int unsigned IdxWidth = $clog2(NumPorts);

   localparam logic [2:0] ACTIVE = ST_ACTIVE;
   localparam logic [2:0] DRAIN  = ST_DRAIN;
   localparam logic [2:0] GATE   = ST_GATE;
   localparam logic [2:0] SLEEP  = ST_SLEEP;
   localparam logic [2:0] WAKE   = ST_WAKE;

   logic [2:0]          state_reg, state_next;
   logic [IdxWidth-1:0] ptr_reg, ptr_next;
   logic [NumPorts-1:0] rvalid_reg;
   logic                wr_resp_reg;
   logic [NumPorts-1:0] arb_gnt, gnt;
   logic [IdxWidth-1:0] gnt_idx;
   logic                grant_en, powered_down;

   rr_arbiter #(
      .NumPorts (NumPorts)
   ) u_rr (
      .req (bus.req_i),
      .ptr (ptr_reg),
      .gnt (arb_gnt),
      .idx (gnt_idx)
   );

   // A sleep request in ACTIVE blocks the grant of that same cycle.
   assign grant_en  = (state_reg == ACTIVE) && !sleep_req_i;
   assign gnt       = grant_en ? arb_gnt : '0;
   assign bus.gnt_o = gnt;

   always_comb begin
      mem_req_o   = |gnt;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (|gnt) begin
         mem_we_o    = bus.we_i[gnt_idx];
         mem_addr_o  = bus.addr_i[gnt_idx];
         mem_wdata_o = bus.wdata_i[gnt_idx];
         mem_be_o    = bus.be_i[gnt_idx];
      end
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (|gnt) begin
         ptr_next = (32'(gnt_idx) == NumPorts - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Once the power-down sequence starts it always runs to SLEEP before waking.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ACTIVE:  if (sleep_req_i)         state_next = DRAIN;
         DRAIN:                            state_next = GATE;
         GATE:    if (!mem_pwrgate_ack_ni) state_next = SLEEP;
         SLEEP:   if (!sleep_req_i)        state_next = WAKE;
         WAKE:    if (mem_pwrgate_ack_ni)  state_next = ACTIVE;
         default:                          state_next = ACTIVE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= ACTIVE;
         ptr_reg     <= '0;
         rvalid_reg  <= '0;
         wr_resp_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         rvalid_reg  <= gnt;
         wr_resp_reg <= mem_we_o;
      end
   end

   assign bus.rvalid_o = rvalid_reg;

   generate
      for (genvar gi = 0; gi < NumPorts; gi++) begin : g_rdata
         assign bus.rdata_o[gi] = (rvalid_reg[gi] && !wr_resp_reg) ? mem_rdata_i : '0;
      end
   endgenerate

   // Reset releases power gating combinationally, without waiting for an edge.
   assign powered_down         = (state_reg == GATE) || (state_reg == SLEEP);
   assign mem_pwrgate_no       = rst_i || !powered_down;
   assign mem_set_retentive_no = rst_i || !(RetentiveSleep && powered_down);
   assign sleep_ack_o          = (state_reg == SLEEP);

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Self-checking bench for sram_bank_arbiter: scoreboarded responses plus per-scenario checks.
module tb_sram_bank_arbiter;
   import sram_arb_pkg::*;

   localparam int unsigned NP = 2;
   localparam int unsigned AW = 13;

   typedef struct {
      int          cyc;
      int          port;
      logic [31:0] data;
   } resp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           mem_req, mem_we;
   logic [AW-1:0]  mem_addr;
   logic [31:0]    mem_wdata;
   logic [3:0]     mem_be;
   logic [31:0]    mem_rdata = '0;
   logic           pwrgate_n, ret_n, ack_n, sleep_req, sleep_ack;

   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   bit    monitor_on = 1'b0;
   resp_t exp_q[$];

   logic [31:0] sram [8192];

   sram_bank_arbiter_if #(.NumPorts(NP), .AddrWidth(AW)) bus ();

   sram_bank_arbiter #(
      .NumPorts       (NP),
      .NumWords       (8192),
      .RetentiveSleep (1'b1)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .bus                  (bus),
      .mem_req_o            (mem_req),
      .mem_we_o             (mem_we),
      .mem_addr_o           (mem_addr),
      .mem_wdata_o          (mem_wdata),
      .mem_be_o             (mem_be),
      .mem_rdata_i          (mem_rdata),
      .mem_pwrgate_no       (pwrgate_n),
      .mem_set_retentive_no (ret_n),
      .mem_pwrgate_ack_ni   (ack_n),
      .sleep_req_i          (sleep_req),
      .sleep_ack_o          (sleep_ack)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM bank model: one-cycle read latency, byte-enabled writes.
   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   // Response scoreboard: every cycle, rvalid/rdata must match the entry due now (or be zero).
   always @(negedge clk) begin
      logic [NP-1:0]       exp_rv;
      logic [NP-1:0][31:0] exp_rd;
      resp_t               r;
      if (monitor_on) begin
         exp_rv = '0;
         exp_rd = '0;
         r      = '{0, 0, 32'h0};
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            r = exp_q.pop_front();
            exp_rv[r.port] = 1'b1;
            exp_rd[r.port] = r.data;
         end
         checks++;
         if (bus.rvalid_o !== exp_rv || bus.rdata_o !== exp_rd) begin
            errors++;
            $display("FAIL response@%0d: rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                     cyc, bus.rvalid_o, bus.rdata_o, exp_rv, exp_rd);
         end else if (exp_rv != '0) begin
            $display("cyc %0d: port %0d response data=%h", cyc, r.port, r.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_i   = '0;
      bus.we_i    = '0;
      bus.addr_i  = '0;
      bus.wdata_i = '0;
      bus.be_i    = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (pwrgate_n !== 1'b1 || ret_n !== 1'b1) begin
         errors++; $display("FAIL reset_power: got %b%b expected 11", pwrgate_n, ret_n);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.rvalid_o !== '0 || sleep_ack !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: rvalid=%b ack=%b expected 0 0", bus.rvalid_o, sleep_ack);
      end
      checks++;
      if (bus.gnt_o !== '0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 ||
          mem_wdata !== '0 || mem_be !== '0) begin
         errors++; $display("FAIL idle_bus: gnt=%b req=%b addr=%h expected all zero", bus.gnt_o, mem_req, mem_addr);
      end
      checks++;
      if (pwrgate_n !== 1'b1) begin
         errors++; $display("FAIL active_power: got %b expected 1", pwrgate_n);
      end
      monitor_on = 1'b1;
      tick();
   endtask

   task automatic test_alternate();
      logic [AW-1:0] a [NP];
      logic [NP-1:0] exp_gnt;
      int            p;
      a[0] = 13'h020;
      a[1] = 13'h028;
      for (int n = 0; n < 6; n++) begin
         p = n % 2;
         bus.req_i     = 2'b11;
         bus.we_i      = '0;
         bus.addr_i[0] = a[0];
         bus.addr_i[1] = a[1];
         exp_gnt       = '0;
         exp_gnt[p]    = 1'b1;
         @(negedge clk);
         checks++;
         if (bus.gnt_o !== exp_gnt) begin
            errors++; $display("FAIL alternate_gnt[%0d]: got %b expected %b", n, bus.gnt_o, exp_gnt);
         end
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== a[p]) begin
            errors++; $display("FAIL alternate_addr[%0d]: got %h expected %h", n, mem_addr, a[p]);
         end
         exp_q.push_back('{cyc + 1, p, sram[a[p]]});
         a[p] = a[p] + 1'b1;
         tick();
      end
      idle();
   endtask

   task automatic test_write_read();
      bus.req_i      = 2'b10;
      bus.we_i       = 2'b10;
      bus.addr_i[1]  = 13'h010;
      bus.wdata_i[1] = 32'hDEADBEEF;
      bus.be_i[1]    = 4'h3;
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 2'b10) begin
         errors++; $display("FAIL write_gnt: got %b expected 10", bus.gnt_o);
      end
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 13'h010 || mem_wdata !== 32'hDEADBEEF || mem_be !== 4'h3) begin
         errors++; $display("FAIL write_bus: we=%b addr=%h wdata=%h be=%h expected 1 010 deadbeef 3",
                            mem_we, mem_addr, mem_wdata, mem_be);
      end
      exp_q.push_back('{cyc + 1, 1, 32'h0});
      tick();
      idle();
      bus.req_i     = 2'b01;
      bus.addr_i[0] = 13'h010;
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 2'b01 || mem_we !== 1'b0 || mem_addr !== 13'h010) begin
         errors++; $display("FAIL readback_gnt: gnt=%b we=%b addr=%h expected 01 0 010", bus.gnt_o, mem_we, mem_addr);
      end
      exp_q.push_back('{cyc + 1, 0, 32'h0000BEEF});
      tick();
      idle();
   endtask

   task automatic test_single_port();
      for (int n = 0; n < 5; n++) begin
         bus.req_i     = 2'b10;
         bus.addr_i[1] = 13'h020 + 13'(n);
         @(negedge clk);
         checks++;
         if (bus.gnt_o !== 2'b10) begin
            errors++; $display("FAIL single_port_gnt[%0d]: got %b expected 10", n, bus.gnt_o);
         end
         exp_q.push_back('{cyc + 1, 1, sram[13'h020 + 13'(n)]});
         tick();
      end
      bus.req_i     = 2'b11;
      bus.addr_i[0] = 13'h02C;
      bus.addr_i[1] = 13'h02D;
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 2'b01) begin
         errors++; $display("FAIL ptr_wrap_gnt: got %b expected 01", bus.gnt_o);
      end
      exp_q.push_back('{cyc + 1, 0, sram[13'h02C]});
      tick();
      idle();
   endtask

   task automatic test_sleep();
      bus.req_i     = 2'b01;
      bus.addr_i[0] = 13'h02E;
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 2'b01) begin
         errors++; $display("FAIL pre_sleep_gnt: got %b expected 01", bus.gnt_o);
      end
      exp_q.push_back('{cyc + 1, 0, sram[13'h02E]});
      tick();
      idle();
      sleep_req     = 1'b1;
      bus.req_i     = 2'b10;
      bus.addr_i[1] = 13'h02F;
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 2'b00) begin
         errors++; $display("FAIL sleep_req_gnt: got %b expected 00", bus.gnt_o);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 2'b00 || pwrgate_n !== 1'b1 || sleep_ack !== 1'b0) begin
         errors++; $display("FAIL drain: gnt=%b pwrgate_n=%b ack=%b expected 00 1 0", bus.gnt_o, pwrgate_n, sleep_ack);
      end
      tick();
      for (int g = 0; g < 3; g++) begin
         if (g == 2) ack_n = 1'b0;
         @(negedge clk);
         checks++;
         if (bus.gnt_o !== 2'b00 || pwrgate_n !== 1'b0 || ret_n !== 1'b0 || sleep_ack !== 1'b0) begin
            errors++; $display("FAIL gate[%0d]: gnt=%b pwrgate_n=%b ret_n=%b ack=%b expected 00 0 0 0",
                               g, bus.gnt_o, pwrgate_n, ret_n, sleep_ack);
         end
         tick();
      end
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         checks++;
         if (bus.gnt_o !== 2'b00 || pwrgate_n !== 1'b0 || ret_n !== 1'b0 || sleep_ack !== 1'b1) begin
            errors++; $display("FAIL sleep[%0d]: gnt=%b pwrgate_n=%b ret_n=%b ack=%b expected 00 0 0 1",
                               s, bus.gnt_o, pwrgate_n, ret_n, sleep_ack);
         end
         tick();
      end
   endtask

   task automatic test_wake();
      sleep_req = 1'b0;
      @(negedge clk);
      checks++;
      if (sleep_ack !== 1'b1 || pwrgate_n !== 1'b0) begin
         errors++; $display("FAIL sleep_exit_cycle: ack=%b pwrgate_n=%b expected 1 0", sleep_ack, pwrgate_n);
      end
      tick();
      for (int w = 0; w < 2; w++) begin
         if (w == 1) ack_n = 1'b1;
         @(negedge clk);
         checks++;
         if (bus.gnt_o !== 2'b00 || pwrgate_n !== 1'b1 || ret_n !== 1'b1 || sleep_ack !== 1'b0) begin
            errors++; $display("FAIL wake[%0d]: gnt=%b pwrgate_n=%b ret_n=%b ack=%b expected 00 1 1 0",
                               w, bus.gnt_o, pwrgate_n, ret_n, sleep_ack);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 2'b10 || mem_addr !== 13'h02F) begin
         errors++; $display("FAIL wake_first_gnt: gnt=%b addr=%h expected 10 02f", bus.gnt_o, mem_addr);
      end
      exp_q.push_back('{cyc + 1, 1, sram[13'h02F]});
      tick();
      idle();
   endtask

   task automatic test_reset_mid_transfer();
      tick();
      bus.req_i     = 2'b01;
      bus.addr_i[0] = 13'h020;
      rst           = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 2'b01) begin
         errors++; $display("FAIL reset_xfer_gnt: got %b expected 01", bus.gnt_o);
      end
      tick();
      rst = 1'b0;
      idle();
      @(negedge clk);
      checks++;
      if (bus.rvalid_o !== 2'b00) begin
         errors++; $display("FAIL reset_suppress_rvalid: got %b expected 00", bus.rvalid_o);
      end
      tick();
      bus.req_i     = 2'b11;
      bus.addr_i[0] = 13'h021;
      bus.addr_i[1] = 13'h022;
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 2'b01) begin
         errors++; $display("FAIL reset_ptr_gnt: got %b expected 01", bus.gnt_o);
      end
      exp_q.push_back('{cyc + 1, 0, sram[13'h021]});
      tick();
      idle();
   endtask

   task automatic test_reset_in_sleep();
      sleep_req = 1'b1;
      tick();
      tick();
      ack_n = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (sleep_ack !== 1'b1 || pwrgate_n !== 1'b0) begin
         errors++; $display("FAIL resleep: ack=%b pwrgate_n=%b expected 1 0", sleep_ack, pwrgate_n);
      end
      tick();
      rst       = 1'b1;
      sleep_req = 1'b0;
      ack_n     = 1'b1;
      @(negedge clk);
      checks++;
      if (pwrgate_n !== 1'b1 || ret_n !== 1'b1) begin
         errors++; $display("FAIL reset_in_sleep_power: got %b%b expected 11", pwrgate_n, ret_n);
      end
      tick();
      rst           = 1'b0;
      bus.req_i     = 2'b01;
      bus.addr_i[0] = 13'h023;
      @(negedge clk);
      checks++;
      if (pwrgate_n !== 1'b1 || sleep_ack !== 1'b0 || bus.gnt_o !== 2'b01) begin
         errors++; $display("FAIL after_sleep_reset: pwrgate_n=%b ack=%b gnt=%b expected 1 0 01",
                            pwrgate_n, sleep_ack, bus.gnt_o);
      end
      exp_q.push_back('{cyc + 1, 0, sram[13'h023]});
      tick();
      idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 8192; i++) sram[i] = '0;
      for (int i = 32; i < 64; i++) sram[i] = {8'hA5, 8'(i), 8'h5A, 8'(i * 3)};
      rst       = 1'b1;
      sleep_req = 1'b0;
      ack_n     = 1'b1;
      idle();
      test_reset();
      test_alternate();
      test_write_read();
      test_single_port();
      test_sleep();
      test_wake();
      test_reset_mid_transfer();
      test_reset_in_sleep();
      tick();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL pending_responses: got %0d outstanding expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
